axis_rr_arbiter: RTL and testbench

//  Packet-locked round-robin arbiter/mux: N slave AXI-Stream ports share one master port of the switch.

---
 rtl/axis_rr_arbiter.sv | 102 ++++++++++
 tb/tb_axis_rr_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_rr_arbiter.sv
// Packet-locked round-robin AXI-Stream mux: one input port owns the output
// from its first beat through LAST, and every beat is tagged with its source port.
module axis_rr_arbiter #(
   parameter int N_PORTS      = 4,
   parameter int T_DATA_WIDTH = 8,
   parameter int T_ID_WIDTH   = 8
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [N_PORTS*T_DATA_WIDTH-1:0]   s_data,
   input  logic [N_PORTS-1:0]                s_last,
   input  logic [N_PORTS-1:0]                s_valid,
   output logic [N_PORTS-1:0]                s_ready,
   output logic [T_ID_WIDTH-1:0]             m_id,
   output logic [T_DATA_WIDTH-1:0]           m_data,
   output logic                              m_last,
   output logic                              m_valid,
   input  logic                              m_ready,
   output logic                              busy
);

   localparam int GW = $clog2(N_PORTS);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t            state_reg, state_next;
   logic [GW-1:0]     grant_reg, grant_next;
   logic [GW-1:0]     last_grant_reg, last_grant_next;
   logic [GW-1:0]     pick;
   logic [N_PORTS-1:0] grant_onehot;
   logic [T_DATA_WIDTH-1:0] s_data_arr [N_PORTS];

   genvar gi;
   generate
      for (gi = 0; gi < N_PORTS; gi++) begin : g_port
         assign s_data_arr[gi]   = s_data[gi*T_DATA_WIDTH +: T_DATA_WIDTH];
         assign grant_onehot[gi] = (state_reg == BUSY) && (grant_reg == GW'(gi));
         assign s_ready[gi]      = grant_onehot[gi] & m_ready;
      end
   endgenerate

   // Round-robin pick: the lowest requester above last_grant wins; if there is
   // none, the search wraps to the lowest requester at or below last_grant.
   always_comb begin
      pick = '0;
      for (int i = N_PORTS - 1; i >= 0; i--) begin
         if (s_valid[i] && (GW'(i) <= last_grant_reg)) begin
            pick = GW'(i);
         end
      end
      for (int i = N_PORTS - 1; i >= 0; i--) begin
         if (s_valid[i] && (GW'(i) > last_grant_reg)) begin
            pick = GW'(i);
         end
      end
   end

   always_comb begin
      state_next      = state_reg;
      grant_next      = grant_reg;
      last_grant_next = last_grant_reg;
      m_valid         = 1'b0;
      m_data          = '0;
      m_last          = 1'b0;
      m_id            = '0;
      busy            = 1'b0;
      case (state_reg)
         IDLE: begin
            if (|s_valid) begin
               grant_next = pick;
               state_next = BUSY;
            end
         end
         BUSY: begin
            busy    = 1'b1;
            m_valid = s_valid[grant_reg];
            m_data  = s_data_arr[grant_reg];
            m_last  = s_last[grant_reg];
            m_id    = T_ID_WIDTH'(grant_reg);
            if (s_valid[grant_reg] && m_ready && s_last[grant_reg]) begin
               state_next      = IDLE;
               last_grant_next = grant_reg;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // last_grant resets to the top port so that port 0 wins the first arbitration.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= IDLE;
         grant_reg      <= '0;
         last_grant_reg <= GW'(N_PORTS - 1);
      end else begin
         state_reg      <= state_next;
         grant_reg      <= grant_next;
         last_grant_reg <= last_grant_next;
      end
   end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Randomised and directed bench for axis_rr_arbiter (5 ports): sources replay
// per-port packet lists, a packet-level model predicts grants and a scoreboard checks delivery.
module tb_axis_rr_arbiter;

   localparam int N    = 5;
   localparam int W    = 8;
   localparam int IW   = 8;
   localparam int MAXB = 64;

   logic           clk = 1'b0;
   logic           reset;
   logic [N*W-1:0] s_data;
   logic [N-1:0]   s_last;
   logic [N-1:0]   s_valid;
   logic [N-1:0]   s_ready;
   logic [IW-1:0]  m_id;
   logic [W-1:0]   m_data;
   logic           m_last;
   logic           m_valid;
   logic           m_ready;
   logic           busy;

   always #5 clk = ~clk;

   axis_rr_arbiter #(
      .N_PORTS     (N),
      .T_DATA_WIDTH(W),
      .T_ID_WIDTH  (IW)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .s_data (s_data),
      .s_last (s_last),
      .s_valid(s_valid),
      .s_ready(s_ready),
      .m_id   (m_id),
      .m_data (m_data),
      .m_last (m_last),
      .m_valid(m_valid),
      .m_ready(m_ready),
      .busy   (busy)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Per-port packet lists: sources consume them, the scoreboard checks against them.
   logic [W-1:0] pk_data [N][MAXB];
   logic         pk_last [N][MAXB];
   int           n_beats [N];
   int           src_idx [N];
   int           sb_idx  [N];
   int           start_dly [N];
   int           order_q [$];
   logic [N-1:0] hs;

   // Packet-level model: is a packet granted, to which port, and who was served last.
   bit mb;
   int mg;
   int ml;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int rr_pick(input int last, input logic [N-1:0] v);
      for (int k = 1; k <= N; k++) begin
         int idx;
         idx = (last + k) % N;
         if (v[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic clear_all();
      for (int p = 0; p < N; p++) begin
         n_beats[p]   = 0;
         src_idx[p]   = 0;
         sb_idx[p]    = 0;
         start_dly[p] = 0;
      end
      order_q.delete();
      s_valid = '0;
      s_last  = '0;
      s_data  = '0;
      hs      = '0;
   endtask

   task automatic add_pkt(input int p, input int len, input int base);
      for (int k = 0; k < len; k++) begin
         pk_data[p][n_beats[p]] = W'(base + k);
         pk_last[p][n_beats[p]] = (k == len - 1);
         n_beats[p]++;
      end
   endtask

   // Holds reset across one edge with sources left as they are, checks the idle outputs.
   task automatic do_reset();
      reset   = 1'b1;
      m_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rst_busy",    busy,    0);
      check("rst_m_valid", m_valid, 0);
      check("rst_s_ready", s_ready, 0);
      check("rst_m_out",   {m_id, m_data, m_last}, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      mb    = 1'b0;
      mg    = 0;
      ml    = N - 1;
   endtask

   task automatic run(input int max_cyc, input int vpct, input int rmode, input int abort_beats);
      int       cyc;
      int       acc;
      int       id;
      bit       done;
      bit       hold;
      logic [W-1:0]  pd;
      logic [IW-1:0] pid;
      logic          pl;
      cyc  = 0;
      acc  = 0;
      done = 1'b0;
      hold = 1'b0;
      pd   = '0;
      pid  = '0;
      pl   = 1'b0;
      hs   = '0;
      while (!done && cyc < max_cyc) begin
         for (int p = 0; p < N; p++) begin
            if (s_valid[p] && hs[p]) begin
               src_idx[p]++;
               s_valid[p] = 1'b0;
            end
            if (!s_valid[p] && src_idx[p] < n_beats[p] && cyc >= start_dly[p]
                && $urandom_range(99) < vpct)
               s_valid[p] = 1'b1;
            if (s_valid[p]) begin
               s_data[p*W +: W] = pk_data[p][src_idx[p]];
               s_last[p]        = pk_last[p][src_idx[p]];
            end else begin
               s_data[p*W +: W] = W'($urandom);
               s_last[p]        = 1'($urandom);
            end
         end
         case (rmode)
            0:       m_ready = 1'b1;
            1:       m_ready = (cyc % 2 == 0);
            default: m_ready = ($urandom_range(99) < 65);
         endcase

         @(negedge clk);
         check("busy", busy, mb);
         if (mb) begin
            check("m_valid", m_valid, s_valid[mg]);
            check("m_id",    m_id,    mg);
            check("m_data",  m_data,  s_data[mg*W +: W]);
            check("m_last",  m_last,  s_last[mg]);
            check("s_ready", s_ready, m_ready ? (32'd1 << mg) : 32'd0);
         end else begin
            check("idle_m_valid", m_valid, 0);
            check("idle_s_ready", s_ready, 0);
            check("idle_m_out",   {m_id, m_data, m_last}, 0);
         end
         if (hold)
            check("hold_stable", {m_valid, m_id, m_data, m_last}, {1'b1, pid, pd, pl});
         hold = m_valid && !m_ready;
         pid  = m_id;
         pd   = m_data;
         pl   = m_last;

         if (m_valid && m_ready) begin
            id = int'(m_id);
            if (id >= N || sb_idx[id] >= n_beats[id]) begin
               check("sb_extra_beat", 1, 0);
            end else begin
               check("sb_data", m_data, pk_data[id][sb_idx[id]]);
               check("sb_last", m_last, pk_last[id][sb_idx[id]]);
               sb_idx[id]++;
               acc++;
               if (m_last)
                  $display("[TB] packet from port %0d delivered, %0d/%0d beats of port done",
                           id, sb_idx[id], n_beats[id]);
            end
         end
         hs = s_valid & s_ready;

         if (!mb) begin
            if (|s_valid) begin
               mg = rr_pick(ml, s_valid);
               mb = 1'b1;
               order_q.push_back(mg);
            end
         end else if (s_valid[mg] && m_ready && s_last[mg]) begin
            mb = 1'b0;
            ml = mg;
         end

         cyc++;
         done = !mb;
         for (int p = 0; p < N; p++)
            if (sb_idx[p] < n_beats[p]) done = 1'b0;
         if (abort_beats > 0 && acc >= abort_beats) done = 1'b1;
         @(posedge clk);
         #1;
      end
      check("run_complete", done, 1);
   endtask

   initial begin
      clear_all();
      m_ready = 1'b1;
      do_reset();

      // Single 3-beat packet on port 0.
      clear_all();
      add_pkt(0, 3, 'hA1);
      run(50, 100, 0, 0);
      check("t1_pkts", order_q.size(), 1);
      check("t1_first", order_q[0], 0);

      // All ports continuously requesting 2-beat packets: strict 0..N-1 rotation.
      do_reset();
      clear_all();
      for (int p = 0; p < N; p++)
         for (int k = 0; k < 3; k++) add_pkt(p, 2, p * 16 + k * 2);
      run(200, 100, 0, 0);
      check("t2_pkts", order_q.size(), 3 * N);
      for (int k = 0; k < order_q.size(); k++) check("t2_rr_order", order_q[k], k % N);

      // Port 2 under toggling backpressure, port 1 raises valid mid-packet.
      clear_all();
      add_pkt(2, 4, 'h20);
      add_pkt(1, 2, 'h10);
      start_dly[1] = 3;
      run(100, 100, 1, 0);
      check("t3_pkts", order_q.size(), 2);
      check("t3_first",  order_q[0], 2);
      check("t3_second", order_q[1], 1);

      // Only port 3 requesting: the search wraps back to it.
      clear_all();
      add_pkt(3, 2, 'h30);
      add_pkt(3, 1, 'h38);
      run(100, 100, 0, 0);
      check("t4_pkts", order_q.size(), 2);
      check("t4_first",  order_q[0], 3);
      check("t4_second", order_q[1], 3);

      // Reset in the middle of a 4-beat packet, then port 0 wins again.
      do_reset();
      clear_all();
      add_pkt(0, 4, 'h40);
      run(50, 100, 0, 2);
      do_reset();
      clear_all();
      for (int p = 0; p < N; p++) add_pkt(p, 1 + p % 3, 'h50 + p * 8);
      run(200, 100, 0, 0);
      check("t5_first_after_rst", order_q[0], 0);

      // Random packets, gaps and backpressure.
      do_reset();
      clear_all();
      for (int p = 0; p < N; p++)
         for (int k = 0; k < 10; k++) add_pkt(p, 1 + $urandom_range(4), $urandom);
      run(5000, 60, 2, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
